// File: rtl/tt_rx_capture_pkg.sv
// Shared definitions for the console receive path.
// Holds the receiver FSM state encoding, default parameter values and a
// helper that sizes the FIFO occupancy count.
package tt_rx_capture_pkg;

    // Receiver FSM states. The 3-bit encoding leaves room for extra states.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 8;

    // The count has to represent 0..depth inclusive, so it needs one more bit
    // than a pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tt_rx_capture_if.sv
// Bundle of the receiver's serial input, pop handshake and status outputs.
//  master : the consumer side (drives rxd, rd, clr_err; observes the rest)
//  slave  : the receiver itself
// Signals:
//  rxd         serial line, idle high
//  rd          pop request for the head byte
//  clr_err     clears the sticky error flags
//  data_out    head byte of the queue (0 when empty)
//  valid       queue non-empty
//  count       bytes currently held
//  framing_err sticky: stop bit sampled low
//  overrun     sticky: byte lost because the queue was full
//  busy        receiver is mid-frame
interface tt_rx_capture_if
    import tt_rx_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) ();
    localparam int CW = count_width(FIFO_DEPTH);

    logic          rxd;
    logic          rd;
    logic          clr_err;
    logic [7:0]    data_out;
    logic          valid;
    logic [CW-1:0] count;
    logic          framing_err;
    logic          overrun;
    logic          busy;

    modport master (
        output rxd, rd, clr_err,
        input  data_out, valid, count, framing_err, overrun, busy
    );

    modport slave (
        input  rxd, rd, clr_err,
        output data_out, valid, count, framing_err, overrun, busy
    );
endinterface

// File: rtl/tt_rx_capture_fifo.sv
// Show-ahead byte queue for received characters.
// Ports:
//  clk, reset  clock and asynchronous active-high reset
//  push, din   write a byte (ignored when full unless a pop happens in the same cycle)
//  pop         remove the head byte (ignored when empty)
//  dout        head byte, 0 while empty
//  count       number of bytes held; the only authority for full/empty
//  full, empty occupancy decodes of count
module tt_rx_fifo
    import tt_rx_capture_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    din,
    input  logic                          pop,
    output logic [7:0]                    dout,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [CW-1:0] count_reg;
    logic [7:0]    slot_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // A push into a full queue is still accepted when the head leaves in the
    // same cycle, because the freed slot is the one being written.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage slots; data needs no reset since count gates visibility.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [7:0] slot_reg;
        always_ff @(posedge clk) begin
            if (do_push && (wptr_reg == AW'(gi))) begin
                slot_reg <= din;
            end
        end
        assign slot_q[gi] = slot_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (do_pop) begin
                rptr_reg <= rptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = empty ? 8'h00 : slot_q[rptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/tt_rx_capture.sv
// Console serial receiver with byte queue.
// Deserialises 8N1 frames from the bus console transmit line, queues good
// bytes and raises sticky flags for framing errors and overruns.
// Ports:
//  clk    system clock, all logic on the rising edge
//  reset  asynchronous active-high reset
//  bus    tt_rx_capture_if.slave: rxd, rd, clr_err in; data_out, valid,
//         count, framing_err, overrun, busy out
module tt_rx_capture
    import tt_rx_capture_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    tt_rx_capture_if.slave  bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = count_width(FIFO_DEPTH);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    // Two-flop synchroniser; both flops reset to the idle line level so a
    // reset never looks like a start bit.
    logic rx_meta_reg;
    logic rxs_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= bus.rxd;
            rxs_reg     <= rx_meta_reg;
        end
    end

    rx_state_t     state_reg;
    logic [TW-1:0] timer_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          armed_reg;
    logic          busy_reg;
    logic          push_reg;
    logic [7:0]    push_data_reg;
    logic          framing_err_reg;
    logic          overrun_reg;

    logic          stop_sample;
    logic          ferr_set;
    logic          ovr_set;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    assign stop_sample = (state_reg == RX_STOP) && (timer_reg == BIT_LAST);
    assign ferr_set    = stop_sample && !rxs_reg;

    // armed_reg blocks a held-low line (break) from re-triggering after a
    // framing error: the line must be seen high before the next start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= RX_IDLE;
            timer_reg     <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            armed_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            push_reg      <= 1'b0;
            push_data_reg <= '0;
        end else begin
            push_reg <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    if (!armed_reg) begin
                        if (rxs_reg) begin
                            armed_reg <= 1'b1;
                        end
                    end else if (!rxs_reg) begin
                        state_reg <= RX_START;
                        busy_reg  <= 1'b1;
                        timer_reg <= '0;
                    end
                end
                RX_START: begin
                    if (timer_reg == HALF_LAST) begin
                        timer_reg <= '0;
                        if (!rxs_reg) begin
                            state_reg   <= RX_DATA;
                            bit_idx_reg <= '0;
                        end else begin
                            // Too short to be a start bit: drop it silently.
                            state_reg <= RX_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (timer_reg == BIT_LAST) begin
                        timer_reg <= '0;
                        shift_reg <= {rxs_reg, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= RX_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                RX_STOP: begin
                    if (timer_reg == BIT_LAST) begin
                        timer_reg <= '0;
                        state_reg <= RX_IDLE;
                        busy_reg  <= 1'b0;
                        if (rxs_reg) begin
                            push_reg      <= 1'b1;
                            push_data_reg <= shift_reg;
                            armed_reg     <= 1'b1;
                        end else begin
                            armed_reg <= 1'b0;
                        end
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                default: begin
                    state_reg <= RX_IDLE;
                    busy_reg  <= 1'b0;
                    timer_reg <= '0;
                end
            endcase
        end
    end

    assign fifo_pop = bus.rd && !fifo_empty;
    // A pop in the same cycle frees the slot, so that case is not an overrun.
    assign ovr_set  = push_reg && fifo_full && !fifo_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else if (bus.clr_err) begin
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            if (ferr_set) begin
                framing_err_reg <= 1'b1;
            end
            if (ovr_set) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    tt_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_reg),
        .din   (push_data_reg),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.data_out    = fifo_dout;
    assign bus.valid       = !fifo_empty;
    assign bus.count       = fifo_count;
    assign bus.framing_err = framing_err_reg;
    assign bus.overrun     = overrun_reg;
    assign bus.busy        = busy_reg;

endmodule
